// File: rtl/chinx_ioport.sv
// GPIO controller: four bidirectional ports with DIR/OUT/IN/IE/IFLAG registers and edge-detect IRQ.
// Optional falling-edge select per bit when CHINX_IOPORT_FALLEDGE_EN is defined.
module chinx_ioport #(
    parameter int unsigned PORT_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [4:0]            addr,
    input  logic [PORT_WIDTH-1:0] wdata,
    output logic [PORT_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  ireq,
    inout  wire  [PORT_WIDTH-1:0] io0,
    inout  wire  [PORT_WIDTH-1:0] io1,
    inout  wire  [PORT_WIDTH-1:0] io2,
    inout  wire  [PORT_WIDTH-1:0] io3
);

    typedef enum logic [2:0] {
        REG_DIR   = 3'd0,
        REG_OUT   = 3'd1,
        REG_IN    = 3'd2,
        REG_IE    = 3'd3,
        REG_IFLAG = 3'd4,
        REG_EDGE  = 3'd5,
        REG_RSV6  = 3'd6,
        REG_RSV7  = 3'd7
    } reg_sel_e;

    logic [PORT_WIDTH-1:0] r_dir   [4];
    logic [PORT_WIDTH-1:0] r_out   [4];
    logic [PORT_WIDTH-1:0] r_ie    [4];
    logic [PORT_WIDTH-1:0] r_iflag [4];
    logic [PORT_WIDTH-1:0] r_prev  [4];
    logic [PORT_WIDTH-1:0] r_sync  [SYNC_STAGES][4];
`ifdef CHINX_IOPORT_FALLEDGE_EN
    logic [PORT_WIDTH-1:0] r_edge  [4];
`endif

    logic [PORT_WIDTH-1:0] w_pin   [4];
    logic [PORT_WIDTH-1:0] w_in    [4];
    logic [PORT_WIDTH-1:0] w_det   [4];
    logic [PORT_WIDTH-1:0] w_clr   [4];
    logic [PORT_WIDTH-1:0] w_rmux;
    logic [1:0]            w_port;
    reg_sel_e              w_sel;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_irq_any;

    assign w_port = addr[1:0];
    assign w_sel  = reg_sel_e'(addr[4:2]);
    assign w_wr   = ce & we;
    assign w_rd   = ce & ~we;

    assign w_pin[0] = io0;
    assign w_pin[1] = io1;
    assign w_pin[2] = io2;
    assign w_pin[3] = io3;

    for (genvar b = 0; b < PORT_WIDTH; b++) begin : g_drv
        assign io0[b] = r_dir[0][b] ? r_out[0][b] : 1'bz;
        assign io1[b] = r_dir[1][b] ? r_out[1][b] : 1'bz;
        assign io2[b] = r_dir[2][b] ? r_out[2][b] : 1'bz;
        assign io3[b] = r_dir[3][b] ? r_out[3][b] : 1'bz;
    end

    // Edge detect and write-1-to-clear mask per port; clear only hits the addressed port.
    always_comb begin
        w_irq_any = 1'b0;
        for (int unsigned p = 0; p < 4; p++) begin
            w_in[p] = r_sync[SYNC_STAGES-1][p];
`ifdef CHINX_IOPORT_FALLEDGE_EN
            w_det[p] = (r_edge[p] & ~w_in[p] & r_prev[p]) |
                       (~r_edge[p] & w_in[p] & ~r_prev[p]);
`else
            w_det[p] = w_in[p] & ~r_prev[p];
`endif
            w_clr[p] = '0;
            if (w_wr && (w_sel == REG_IFLAG) && (w_port == 2'(p))) begin
                w_clr[p] = wdata;
            end
            w_irq_any = w_irq_any | (|(r_iflag[p] & r_ie[p]));
        end
    end

    always_comb begin
        w_rmux = '0;
        case (w_sel)
            REG_DIR:   w_rmux = r_dir[w_port];
            REG_OUT:   w_rmux = r_out[w_port];
            REG_IN:    w_rmux = w_in[w_port];
            REG_IE:    w_rmux = r_ie[w_port];
            REG_IFLAG: w_rmux = r_iflag[w_port];
`ifdef CHINX_IOPORT_FALLEDGE_EN
            REG_EDGE:  w_rmux = r_edge[w_port];
`endif
            default:   w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned p = 0; p < 4; p++) begin
                r_dir[p]   <= '0;
                r_out[p]   <= '0;
                r_ie[p]    <= '0;
                r_iflag[p] <= '0;
                r_prev[p]  <= '0;
`ifdef CHINX_IOPORT_FALLEDGE_EN
                r_edge[p]  <= '0;
`endif
                for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                    r_sync[s][p] <= '0;
                end
            end
            rdata  <= '0;
            rvalid <= 1'b0;
            ireq   <= 1'b0;
        end else begin
            r_sync[0] <= w_pin;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= w_in;

            rvalid <= w_rd;
            if (w_rd) begin
                rdata <= w_rmux;
            end

            // A new edge in the same cycle as its clear keeps the flag set.
            for (int unsigned p = 0; p < 4; p++) begin
                r_iflag[p] <= (r_iflag[p] & ~w_clr[p]) | w_det[p];
                if (w_wr && (w_port == 2'(p))) begin
                    case (w_sel)
                        REG_DIR: r_dir[p] <= wdata;
                        REG_OUT: r_out[p] <= wdata;
                        REG_IE:  r_ie[p]  <= wdata;
`ifdef CHINX_IOPORT_FALLEDGE_EN
                        REG_EDGE: r_edge[p] <= wdata;
`endif
                        default: ;
                    endcase
                end
            end

            ireq <= w_irq_any;
        end
    end

endmodule

// File: tb/tb_chinx_ioport.sv
// Bench for chinx_ioport: pin-history model checked every cycle plus directed literal checks.
// Honours CHINX_IOPORT_FALLEDGE_EN for the falling-edge scenario.
`timescale 1ns/1ps
module tb_chinx_ioport;
    localparam int unsigned PW = 8;
    localparam int unsigned S  = 2;

    localparam logic [2:0] R_DIR   = 3'd0;
    localparam logic [2:0] R_OUT   = 3'd1;
    localparam logic [2:0] R_IN    = 3'd2;
    localparam logic [2:0] R_IE    = 3'd3;
    localparam logic [2:0] R_IFLAG = 3'd4;
    localparam logic [2:0] R_EDGE  = 3'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          we = 1'b0;
    logic [4:0]    addr = '0;
    logic [PW-1:0] wdata = '0;
    logic [PW-1:0] rdata;
    logic          rvalid;
    logic          ireq;
    wire  [PW-1:0] io0, io1, io2, io3;

    logic [PW-1:0] tb_val [4];
    logic          chk_en = 1'b0;
    int            checks = 0;
    int            errors = 0;

    logic [PW-1:0] m_dir [4], m_out [4], m_ie [4], m_iflag [4], m_edge [4];
    logic [PW-1:0] m_hist [4][S+1];
    logic [PW-1:0] m_rdata;
    logic          m_rvalid, m_ireq;

    chinx_ioport #(.PORT_WIDTH(PW), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .ireq(ireq),
        .io0(io0), .io1(io1), .io2(io2), .io3(io3)
    );

    always #5 clk = ~clk;

    // External device drives every bit the model says the DUT leaves undriven.
    for (genvar b = 0; b < PW; b++) begin : g_ext
        assign io0[b] = m_dir[0][b] ? 1'bz : tb_val[0][b];
        assign io1[b] = m_dir[1][b] ? 1'bz : tb_val[1][b];
        assign io2[b] = m_dir[2][b] ? 1'bz : tb_val[2][b];
        assign io3[b] = m_dir[3][b] ? 1'bz : tb_val[3][b];
    end

    function automatic logic [PW-1:0] exp_pin(input int p);
        return (m_dir[p] & m_out[p]) | (~m_dir[p] & tb_val[p]);
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: IN is the pin value S edges ago, prev the one before; flags, reads from pre-edge state.
    always @(posedge clk) begin : model
        logic [PW-1:0] pin_now [4];
        logic [PW-1:0] rise [4];
        logic [PW-1:0] in_o, prev_o;
        logic          any;
        int unsigned   ap;
        if (!rst) begin
            for (int p = 0; p < 4; p++) begin
                m_dir[p] = '0; m_out[p] = '0; m_ie[p] = '0; m_iflag[p] = '0; m_edge[p] = '0;
                for (int i = 0; i <= S; i++) m_hist[p][i] = '0;
            end
            m_rdata = '0; m_rvalid = 1'b0; m_ireq = 1'b0;
        end else begin
            any = 1'b0;
            for (int p = 0; p < 4; p++) begin
                pin_now[p] = exp_pin(p);
                in_o   = m_hist[p][S-1];
                prev_o = m_hist[p][S];
                rise[p] = (m_edge[p] & ~in_o & prev_o) | (~m_edge[p] & in_o & ~prev_o);
                if ((m_iflag[p] & m_ie[p]) != '0) any = 1'b1;
            end
            ap = addr[1:0];
            m_rvalid = ce && !we;
            if (ce && !we) begin
                case (addr[4:2])
                    R_DIR:   m_rdata = m_dir[ap];
                    R_OUT:   m_rdata = m_out[ap];
                    R_IN:    m_rdata = m_hist[ap][S-1];
                    R_IE:    m_rdata = m_ie[ap];
                    R_IFLAG: m_rdata = m_iflag[ap];
                    R_EDGE:  m_rdata = m_edge[ap];
                    default: m_rdata = '0;
                endcase
            end
            if (ce && we) begin
                case (addr[4:2])
                    R_DIR:   m_dir[ap] = wdata;
                    R_OUT:   m_out[ap] = wdata;
                    R_IE:    m_ie[ap] = wdata;
                    R_IFLAG: m_iflag[ap] = m_iflag[ap] & ~wdata;
`ifdef CHINX_IOPORT_FALLEDGE_EN
                    R_EDGE:  m_edge[ap] = wdata;
`endif
                    default: ;
                endcase
            end
            for (int p = 0; p < 4; p++) begin
                m_iflag[p] = m_iflag[p] | rise[p];
                for (int i = S; i > 0; i--) m_hist[p][i] = m_hist[p][i-1];
                m_hist[p][0] = pin_now[p];
            end
            m_ireq = any;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rdata", rdata, m_rdata);
            chk("m_rvalid", {7'b0, rvalid}, {7'b0, m_rvalid});
            chk("m_ireq", {7'b0, ireq}, {7'b0, m_ireq});
            chk("m_io0", io0, exp_pin(0));
            chk("m_io1", io1, exp_pin(1));
            chk("m_io2", io2, exp_pin(2));
            chk("m_io3", io3, exp_pin(3));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] p, input logic [2:0] r, input logic [PW-1:0] d);
        addr = {r, p}; wdata = d; ce = 1'b1; we = 1'b1;
        cyc();
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] p, input logic [2:0] r,
                      input logic [PW-1:0] exp);
        addr = {r, p}; ce = 1'b1; we = 1'b0;
        cyc();
        ce = 1'b0;
        chk(name, rdata, exp);
        chk({name, "_rvalid"}, {7'b0, rvalid}, 8'h01);
    endtask

    initial begin
        for (int p = 0; p < 4; p++) tb_val[p] = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;

        for (int p = 0; p < 4; p++) begin
            rd("rst_dir", 2'(p), R_DIR, 8'h00);
            rd("rst_out", 2'(p), R_OUT, 8'h00);
            rd("rst_ie", 2'(p), R_IE, 8'h00);
            rd("rst_iflag", 2'(p), R_IFLAG, 8'h00);
        end
        chk("rst_ireq", {7'b0, ireq}, 8'h00);

        tb_val[1] = 8'hA0;
        wr(1, R_DIR, 8'h0F);
        wr(1, R_OUT, 8'hA5);
        chk("io1_drive", io1, 8'hA5);
        repeat (S + 1) cyc();
        rd("in1", 1, R_IN, 8'hA5);

        wr(2, R_IE, 8'h01);
        tb_val[2] = 8'h01;
        repeat (S + 1) cyc();
        chk("ireq_before", {7'b0, ireq}, 8'h00);
        rd("iflag2_set", 2, R_IFLAG, 8'h01);
        chk("ireq_set", {7'b0, ireq}, 8'h01);
        wr(2, R_IFLAG, 8'h01);
        chk("ireq_hold", {7'b0, ireq}, 8'h01);
        cyc();
        chk("ireq_clr", {7'b0, ireq}, 8'h00);
        rd("iflag2_clr", 2, R_IFLAG, 8'h00);

        tb_val[3] = 8'h80;
        repeat (S + 1) cyc();
        rd("iflag3_noie", 3, R_IFLAG, 8'h80);
        chk("ireq_noie", {7'b0, ireq}, 8'h00);
        wr(3, R_IE, 8'h80);
        cyc();
        chk("ireq_late_ie", {7'b0, ireq}, 8'h01);

        tb_val[0] = 8'h08;
        repeat (S) cyc();
        wr(0, R_IFLAG, 8'h08);
        rd("set_wins", 0, R_IFLAG, 8'h08);
        wr(0, R_IFLAG, 8'h08);
        rd("iflag0_clr", 0, R_IFLAG, 8'h00);

        wr(0, 3'd6, 8'hFF);
        rd("rsv6", 0, 3'd6, 8'h00);
        rd("rsv7", 1, 3'd7, 8'h00);
`ifdef CHINX_IOPORT_FALLEDGE_EN
        wr(0, R_EDGE, 8'h01);
        rd("edge0", 0, R_EDGE, 8'h01);
        wr(0, R_IE, 8'h01);
        tb_val[0] = 8'h09;
        repeat (S + 2) cyc();
        rd("fall_rise_ignored", 0, R_IFLAG, 8'h00);
        tb_val[0] = 8'h08;
        repeat (S + 1) cyc();
        rd("fall_set", 0, R_IFLAG, 8'h01);
        chk("fall_ireq", {7'b0, ireq}, 8'h01);
`else
        wr(0, R_EDGE, 8'hFF);
        rd("edge_absent", 0, R_EDGE, 8'h00);
`endif

        for (int i = 0; i < 8; i++) begin
            addr = {3'(i % 5), 2'(i % 4)};
            ce = 1'b1; we = 1'b0;
            cyc();
        end
        ce = 1'b0;

        addr = {R_IFLAG, 2'd3}; ce = 1'b1; we = 1'b0; rst = 1'b0;
        cyc();
        chk("midrst_rvalid", {7'b0, rvalid}, 8'h00);
        chk("midrst_ireq", {7'b0, ireq}, 8'h00);
        chk("midrst_rdata", rdata, 8'h00);
        ce = 1'b0; rst = 1'b1;
        rd("post_rst_iflag3", 3, R_IFLAG, 8'h00);
        rd("post_rst_dir1", 1, R_DIR, 8'h00);
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
